// File: rtl/x_hazard_ctrl.sv
// x_hazard_ctrl
// Execute-stage control for the pipelined RV32 core. Decodes the instruction
// held in X, keeps a short history of in-flight register producers and
// derives from them the operand forwarding selects, ALU source selects,
// branch/jump redirect, data-memory enables, load-use stall and a
// multi-cycle wrong-path flush. Two saturating perf counters track stalls
// and redirects.
//
// Ports
//   clk, reset_n          clock (rising edge) / asynchronous active-low reset
//   x_valid, x_inst       X holds a real instruction / its encoding
//   br_eq, br_lt          branch comparator results (signedness per br_un)
//   ext_stall             whole pipeline frozen by a memory wait
//   fwd_sel1, fwd_sel2    rs1/rs2 source: 0 = regfile, k = producer k cycles older
//   a_use_pc, b_use_imm   ALU operand A = PC / operand B = immediate
//   br_un                 comparator runs unsigned
//   pc_sel                redirect fetch to the ALU result
//   dmem_re, dmem_we      data memory read / write enable
//   stall                 load-use stall (hold F/D/X, inject bubble)
//   flush                 squash younger wrong-path instructions
//   stall_cnt             cycles spent in load-use stall
//   redirect_cnt          number of taken redirects
module x_hazard_ctrl #(
    parameter int NUM_FWD      = 2,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32,
    localparam int FSW         = $clog2(NUM_FWD + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x_valid,
    input  logic [31:0]      x_inst,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             ext_stall,
    output logic [FSW-1:0]   fwd_sel1,
    output logic [FSW-1:0]   fwd_sel2,
    output logic             a_use_pc,
    output logic             b_use_imm,
    output logic             br_un,
    output logic             pc_sel,
    output logic             dmem_re,
    output logic             dmem_we,
    output logic             stall,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;

    // Producer history: slot 0 is the instruction that left X last cycle.
    logic [NUM_FWD-1:0] hist_vld;
    logic [NUM_FWD-1:0] hist_ld;
    logic [4:0]         hist_rd [NUM_FWD];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       unused_funct7;

    assign opcode        = x_inst[6:0];
    assign funct3        = x_inst[14:12];
    assign rd            = x_inst[11:7];
    assign rs1           = x_inst[19:15];
    assign rs2           = x_inst[24:20];
    assign unused_funct7 = ^x_inst[31:25];

    // Anything not effective (invalid, flushing, or in reset) is a bubble.
    logic eff;
    assign eff = reset_n && x_valid && (state == RUN);

    logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_lui, is_auipc, is_csr;

    assign is_r      = eff && (opcode == OPC_R);
    assign is_i      = eff && (opcode == OPC_I);
    assign is_load   = eff && (opcode == OPC_LOAD);
    assign is_store  = eff && (opcode == OPC_STORE);
    assign is_branch = eff && (opcode == OPC_BRANCH);
    assign is_jal    = eff && (opcode == OPC_JAL);
    assign is_jalr   = eff && (opcode == OPC_JALR);
    assign is_lui    = eff && (opcode == OPC_LUI);
    assign is_auipc  = eff && (opcode == OPC_AUIPC);
    // funct3 == 0 under SYSTEM is ECALL/EBREAK/xRET, which write nothing.
    assign is_csr    = eff && (opcode == OPC_SYSTEM) && (funct3 != 3'b000);

    logic writes_rd, reads_rs1, reads_rs2;
    assign writes_rd = is_r || is_i || is_load || is_jal || is_jalr ||
                       is_lui || is_auipc || is_csr;
    assign reads_rs1 = is_r || is_i || is_load || is_store || is_branch ||
                       is_jalr || (is_csr && (funct3 == 3'b001));
    assign reads_rs2 = is_r || is_store || is_branch;

    // ------------------------------------------------------------------
    // Forwarding and load-use detection
    // ------------------------------------------------------------------
    logic [FSW-1:0] sel1, sel2;
    logic           young1, young2;
    logic           use1, use2;

    always_comb begin
        sel1   = '0;
        sel2   = '0;
        young1 = 1'b0;
        young2 = 1'b0;
        // Walk from oldest to youngest so the youngest match wins.
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if (hist_vld[j] && (hist_rd[j] == rs1)) begin
                sel1   = FSW'(j + 1);
                young1 = hist_ld[j] && (j < LOAD_LAT);
            end
            if (hist_vld[j] && (hist_rd[j] == rs2)) begin
                sel2   = FSW'(j + 1);
                young2 = hist_ld[j] && (j < LOAD_LAT);
            end
        end
    end

    assign use1  = reads_rs1 && (rs1 != 5'd0) && (sel1 != '0);
    assign use2  = reads_rs2 && (rs2 != 5'd0) && (sel2 != '0);
    assign stall = (use1 && young1) || (use2 && young2);

    assign fwd_sel1 = (use1 && !stall) ? sel1 : '0;
    assign fwd_sel2 = (use2 && !stall) ? sel2 : '0;

    // ------------------------------------------------------------------
    // Operand selects, memory, branch resolution
    // ------------------------------------------------------------------
    logic taken;

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = br_eq;
            3'b001:         taken = !br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = !br_lt;
            default:        taken = 1'b0;
        endcase
    end

    assign a_use_pc  = is_branch || is_jal || is_auipc;
    assign b_use_imm = eff && (opcode != OPC_R);
    assign br_un     = is_branch && ((funct3 == 3'b110) || (funct3 == 3'b111));
    assign dmem_re   = is_load && !stall;
    assign dmem_we   = is_store && !stall;
    // A stalled instruction is re-presented next cycle, so it must not redirect yet.
    assign pc_sel    = !stall && (is_jal || is_jalr || (is_branch && taken));

    // ------------------------------------------------------------------
    // History shift register
    // ------------------------------------------------------------------
    logic rec_vld;
    assign rec_vld = writes_rd && !stall && (rd != 5'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_vld <= '0;
        end else if (!ext_stall) begin
            hist_vld <= {hist_vld[NUM_FWD-1:0] << 1} | NUM_FWD'(rec_vld);
        end
    end

    // rd/is_load are only meaningful alongside hist_vld, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!ext_stall) begin
            for (int i = NUM_FWD - 1; i > 0; i--) begin
                hist_rd[i] <= hist_rd[i-1];
                hist_ld[i] <= hist_ld[i-1];
            end
            hist_rd[0] <= rd;
            hist_ld[0] <= is_load;
        end
    end

    // ------------------------------------------------------------------
    // Flush FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (!ext_stall) begin
            case (state)
                RUN: begin
                    if (pc_sel) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FCNT_INIT;
                    end
                end
                FLUSH: begin
                    fcnt_nxt = fcnt - 3'd1;
                    if (fcnt == 3'd1) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_comb begin
        flush = (state == FLUSH);
    end

    // ------------------------------------------------------------------
    // Perf counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else if (!ext_stall) begin
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            // pc_sel only asserts while in RUN, so this is the RUN->FLUSH edge.
            if (pc_sel) begin
                redirect_cnt <= sat_inc(redirect_cnt);
            end
        end
    end

endmodule

// File: tb/tb_x_hazard_ctrl.sv
// Testbench for x_hazard_ctrl with NUM_FWD=2, LOAD_LAT=1, FLUSH_CYCLES=2.
// Each step drives one X-stage instruction, pushes the expected output vector
// to a scoreboard queue, and pops/compares it mid-cycle.
module tb_x_hazard_ctrl;

    localparam int NUM_FWD      = 2;
    localparam int LOAD_LAT     = 1;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 32;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b1;
    logic        x_valid   = 1'b0;
    logic [31:0] x_inst    = 32'd0;
    logic        br_eq     = 1'b0;
    logic        br_lt     = 1'b0;
    logic        ext_stall = 1'b0;

    logic [1:0]       fwd_sel1, fwd_sel2;
    logic             a_use_pc, b_use_imm, br_un, pc_sel;
    logic             dmem_re, dmem_we, stall, flush;
    logic [CNT_W-1:0] stall_cnt, redirect_cnt;

    x_hazard_ctrl #(
        .NUM_FWD(NUM_FWD), .LOAD_LAT(LOAD_LAT),
        .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x_valid(x_valid), .x_inst(x_inst),
        .br_eq(br_eq), .br_lt(br_lt), .ext_stall(ext_stall),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .a_use_pc(a_use_pc), .b_use_imm(b_use_imm), .br_un(br_un),
        .pc_sel(pc_sel), .dmem_re(dmem_re), .dmem_we(dmem_we),
        .stall(stall), .flush(flush),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    // Output vector: fwd1, fwd2, then {a_use_pc,b_use_imm,br_un,pc_sel,dmem_re,dmem_we,stall,flush}
    typedef struct packed {
        logic [1:0] f1;
        logic [1:0] f2;
        logic [7:0] fl;
    } out_t;

    // ctl = {x_valid, br_eq, br_lt, ext_stall}
    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] inst;
        out_t        exp;
    } step_t;

    out_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic out_t ex(input int f1, input int f2, input logic [7:0] fl);
        return {2'(f1), 2'(f2), fl};
    endfunction

    function automatic step_t st(input logic [3:0] ctl, input logic [31:0] inst, input out_t e);
        return {ctl, inst, e};
    endfunction

    function automatic out_t obs();
        return {fwd_sel1, fwd_sel2, a_use_pc, b_use_imm, br_un, pc_sel,
                dmem_re, dmem_we, stall, flush};
    endfunction

    function automatic logic [31:0] r_add(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] i_addi(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] br(input int f3, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'(f3), 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd);
        return {20'd0, 5'(rd), 7'b1101111};
    endfunction

    task automatic drive(input logic [3:0] ctl, input logic [31:0] inst);
        x_valid   = ctl[3];
        br_eq     = ctl[2];
        br_lt     = ctl[1];
        ext_stall = ctl[0];
        x_inst    = inst;
    endtask

    task automatic test_reset();
        step_t s[$];
        out_t  e, o;
        x_valid = 1'b1; x_inst = jal(1); br_eq = 1'b1; br_lt = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(ex(0, 0, 8'b0));
        @(negedge clk);
        e = sb.pop_front(); o = obs(); tests++;
        if (o !== e) begin failed++; $display("FAIL reset_outputs: got %b expected %b", o, e); end
        tests++;
        if (stall_cnt !== 0 || redirect_cnt !== 0) begin
            failed++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, redirect_cnt);
        end
        x_valid = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;
        // Invalid producers of x1 must not enter the history.
        s.push_back(st(4'b0000, r_add(1, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b0000, r_add(1, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b0000, r_add(1, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b1000, r_add(4, 1, 1), ex(0, 0, 8'b0)));
        foreach (s[i]) begin
            drive(s[i].ctl, s[i].inst);
            sb.push_back(s[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = obs(); tests++;
            if (o !== e) begin failed++; $display("FAIL reset_empty step %0d: got %b expected %b", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forward();
        step_t s[$];
        out_t  e, o;
        s.push_back(st(4'b1000, r_add(1, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b1000, r_add(4, 1, 1), ex(1, 1, 8'b0)));
        s.push_back(st(4'b1000, r_add(1, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b1000, i_addi(0, 0),   ex(0, 0, 8'b01000000)));
        s.push_back(st(4'b1000, r_add(4, 1, 1), ex(2, 2, 8'b0)));
        s.push_back(st(4'b1000, r_add(0, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b1000, r_add(5, 0, 4), ex(0, 2, 8'b0)));
        s.push_back(st(4'b1000, r_add(1, 2, 3), ex(0, 0, 8'b0)));
        s.push_back(st(4'b1000, r_add(1, 5, 5), ex(2, 2, 8'b0)));
        s.push_back(st(4'b1000, r_add(6, 1, 1), ex(1, 1, 8'b0)));
        foreach (s[i]) begin
            drive(s[i].ctl, s[i].inst);
            sb.push_back(s[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = obs(); tests++;
            if (o !== e) begin failed++; $display("FAIL forward step %0d: got %b expected %b", i, o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        step_t s[$];
        out_t  e, o;
        s.push_back(st(4'b1000, lw(5, 6),       ex(1, 0, 8'b01001000)));
        s.push_back(st(4'b1000, r_add(7, 5, 0), ex(0, 0, 8'b00000010)));
        s.push_back(st(4'b1000, r_add(7, 5, 0), ex(2, 0, 8'b0)));
        s.push_back(st(4'b1000, lw(8, 0),       ex(0, 0, 8'b01001000)));
        s.push_back(st(4'b1000, sw(8, 9),       ex(0, 0, 8'b01000010)));
        s.push_back(st(4'b1000, sw(8, 9),       ex(0, 2, 8'b01000100)));
        foreach (s[i]) begin
            drive(s[i].ctl, s[i].inst);
            sb.push_back(s[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = obs(); tests++;
            if (o !== e) begin failed++; $display("FAIL load_use step %0d: got %b expected %b", i, o, e); end
            if (i == 2) begin
                tests++;
                if (stall_cnt !== 1) begin failed++; $display("FAIL stall_cnt_first: got %0d expected 1", stall_cnt); end
            end
            @(posedge clk); #1;
        end
        tests++;
        if (stall_cnt !== 2) begin failed++; $display("FAIL stall_cnt_second: got %0d expected 2", stall_cnt); end
    endtask

    task automatic test_branch();
        step_t s[$];
        out_t  e, o;
        s.push_back(st(4'b1100, br(0, 1, 2), ex(0, 0, 8'b11010000)));
        s.push_back(st(4'b1000, sw(3, 4),    ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b1000, sw(3, 4),    ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b1000, i_addi(0, 0), ex(0, 0, 8'b01000000)));
        foreach (s[i]) begin
            drive(s[i].ctl, s[i].inst);
            sb.push_back(s[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = obs(); tests++;
            if (o !== e) begin failed++; $display("FAIL branch step %0d: got %b expected %b", i, o, e); end
            @(posedge clk); #1;
        end
        tests++;
        if (redirect_cnt !== 1) begin failed++; $display("FAIL redirect_cnt_branch: got %0d expected 1", redirect_cnt); end
    endtask

    task automatic test_compare();
        step_t s[$];
        out_t  e, o;
        s.push_back(st(4'b1000, br(6, 1, 2), ex(0, 0, 8'b11100000)));
        s.push_back(st(4'b1110, br(2, 1, 2), ex(0, 0, 8'b11000000)));
        s.push_back(st(4'b1000, br(5, 1, 2), ex(0, 0, 8'b11010000)));
        s.push_back(st(4'b1000, jal(1),      ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b1000, jal(1),      ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b1000, i_addi(0, 0), ex(0, 0, 8'b01000000)));
        foreach (s[i]) begin
            drive(s[i].ctl, s[i].inst);
            sb.push_back(s[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = obs(); tests++;
            if (o !== e) begin failed++; $display("FAIL compare step %0d: got %b expected %b", i, o, e); end
            @(posedge clk); #1;
        end
        tests++;
        if (redirect_cnt !== 2) begin failed++; $display("FAIL redirect_cnt_compare: got %0d expected 2", redirect_cnt); end
    endtask

    task automatic test_freeze_reset();
        step_t s[$];
        out_t  e, o;
        s.push_back(st(4'b1000, jal(1),       ex(0, 0, 8'b11010000)));
        s.push_back(st(4'b0001, i_addi(0, 0), ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b0001, i_addi(0, 0), ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b0001, i_addi(0, 0), ex(0, 0, 8'b00000001)));
        s.push_back(st(4'b0000, i_addi(0, 0), ex(0, 0, 8'b00000001)));
        // Still flushing: the frozen cycles must not have consumed the counter.
        s.push_back(st(4'b0000, i_addi(0, 0), ex(0, 0, 8'b00000001)));
        foreach (s[i]) begin
            drive(s[i].ctl, s[i].inst);
            sb.push_back(s[i].exp);
            @(negedge clk);
            e = sb.pop_front(); o = obs(); tests++;
            if (o !== e) begin failed++; $display("FAIL freeze step %0d: got %b expected %b", i, o, e); end
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        tests++;
        if (redirect_cnt !== 3) begin failed++; $display("FAIL redirect_cnt_freeze: got %0d expected 3", redirect_cnt); end
        // Asynchronous reset mid-flush, between clock edges.
        reset_n = 1'b0;
        #1;
        sb.push_back(ex(0, 0, 8'b0));
        e = sb.pop_front(); o = obs(); tests++;
        if (o !== e) begin failed++; $display("FAIL reset_mid_flush: got %b expected %b", o, e); end
        tests++;
        if (stall_cnt !== 0 || redirect_cnt !== 0) begin
            failed++; $display("FAIL reset_mid_counters: got %0d/%0d expected 0/0", stall_cnt, redirect_cnt);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        drive(4'b1000, r_add(4, 1, 1));
        sb.push_back(ex(0, 0, 8'b0));
        @(negedge clk);
        e = sb.pop_front(); o = obs(); tests++;
        if (o !== e) begin failed++; $display("FAIL history_cleared: got %b expected %b", o, e); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_compare();
        test_freeze_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
